mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access sequencer sitting directly downstream of the memory address register: takes the latched address (MAR output) plus write data, and runs one read or write to the synchronous external/program memory with a fixed number of wait states. It is started by the control unit via request pulses and reports completion with a single-cycle `done`. Read data is registered for the memory data register.

## Interface
- `ADDR_W`, 16, address width (matches MAR width)
- `DATA_W`, 16, data width
- `WAIT_CYCLES`, 2, memory access wait states; legal range 1..15

- `clk` in 1: system clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `addr_in` in ADDR_W: address from MAR `data_out`
- `wdata_in` in DATA_W: write data from MDR
- `rd_req` in 1: read request, sampled in IDLE only
- `wr_req` in 1: write request, sampled in IDLE only
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when an access completes
- `err` out 1: one-cycle pulse on illegal request (`rd_req` and `wr_req` both high)
- `rdata_out` out DATA_W: registered read data; holds until the next read completes
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_en` out 1: memory enable
- `mem_we` out 1: memory write enable
- `mem_rdata` in DATA_W: memory read data, valid on the last ACCESS cycle

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: exactly one of `rd_req`/`wr_req` high → latch `addr_in`, `wdata_in`, and op (read/write) into internal registers; go to SETUP. Both high → `err`=1 for the next cycle, no latch, stay IDLE. Neither → stay.
- SETUP (1 cycle): `mem_en`=1, `mem_addr`/`mem_wdata` drive the latched values, `mem_we`=1 if write. Load the wait counter with WAIT_CYCLES−1. Go to ACCESS.
- ACCESS (WAIT_CYCLES cycles): `mem_en`, `mem_we`, and address/data are held stable. Counter decrements each cycle. At count 0: capture `mem_rdata` into `rdata_out` if read; go to DONE.
- DONE (1 cycle): `done`=1, `mem_en`=`mem_we`=0. Go to IDLE.
- Requests arriving while `busy` are ignored, not queued. The control unit must re-request after `done`.
- A write never modifies `rdata_out`.
- `addr_in`/`wdata_in` changes after the latch edge have no effect on an access in flight.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata_out`=0, `mem_addr`=0, `mem_wdata`=0, `mem_en`=0, `mem_we`=0. State is IDLE and the counter is 0.
- Request sampled at edge T0. SETUP occupies T0..T1. ACCESS occupies T1..T1+WAIT_CYCLES. `done` is high for the cycle after that.
  - Total: `done` is high WAIT_CYCLES+2 cycles after the sampling edge. Default: the 4th cycle.
- `rdata_out` is updated on the same edge that raises `done`.
- `busy` rises on the cycle after the sampling edge. It falls on the edge that ends DONE, so back-to-back accesses are possible with one IDLE cycle between them.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `reset` mid-access: the next edge forces IDLE and all reset values. No `done` is issued and the access is abandoned. `rdata_out` is cleared.
- `reset` has priority over any request on the same edge.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE, SETUP, ACCESS, DONE)
  - op constant (OP_RD, OP_WR)
  - WAIT_CYCLES default
  - counter width (4 bits)
- One natural sub-module: `mem_wait_cnt`. It is a loadable down-counter with a `zero` flag and synchronous reset. The FSM and datapath latches stay in `mem_ctrl`.

## Test plan
- Read, default params: `addr_in`=0x1234, `rd_req` pulse, memory model returns 0xBEEF.
  - `mem_en` is high for 3 cycles with `mem_addr`=0x1234 and `mem_we`=0.
  - `done` pulses on the 4th cycle with `rdata_out`=0xBEEF.
- Write: `addr_in`=0x00FF, `wdata_in`=0xA5A5, `wr_req`.
  - `mem_we`=1 for 3 cycles; the memory model holds 0xA5A5 at 0x00FF.
  - `done` pulses on the 4th cycle; `rdata_out` is unchanged.
- Illegal request: `rd_req`=`wr_req`=1 in IDLE → `err` pulses one cycle; `mem_en` stays 0; `busy` stays 0.
- Busy/stability: start a read at 0x0010; while busy, assert `wr_req` and change `addr_in` to 0xFFFF.
  - `mem_addr` stays 0x0010 and no write occurs.
  - Exactly one `done` is issued.
- Reset mid-op: assert `reset` for one cycle during ACCESS.
  - All outputs read 0 the following cycle and no `done` is issued.
  - A new read to 0x0002 afterwards completes normally.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds: read latency to `done` is 3 and 17 cycles respectively. Back-to-back reads show one IDLE cycle between them.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StDone   = 2'd3
    } mem_state_e;

    // Access direction
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Default wait states and wait counter width (covers 1..15)
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter used to time the ACCESS phase; stops at zero.
module mem_wait_cnt
    import mem_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: load has priority over decrement, never wraps below zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer: one read or write per request with fixed wait states.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e        r_state, w_state_d;
    logic              r_op, w_op_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_busy, r_done, r_err, r_mem_en, r_mem_we;
    logic              w_busy_d, w_done_d, w_err_d, w_mem_en_d, w_mem_we_d;
    logic              w_latch, w_capture, w_cnt_load, w_cnt_dec, w_cnt_zero;

    // A request is accepted only in IDLE and only when exactly one is raised
    assign w_latch    = (r_state == StIdle) && (rd_req ^ wr_req);
    assign w_cnt_load = (r_state == StSetup);
    assign w_cnt_dec  = (r_state == StAccess);
    assign w_capture  = (r_state == StAccess) && w_cnt_zero && (r_op == OP_RD);

    mem_wait_cnt u_wait_cnt (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_load     (w_cnt_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (rd_req ^ wr_req) w_state_d = StSetup;
            StSetup:  w_state_d = StAccess;
            StAccess: if (w_cnt_zero) w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop
    always_comb begin
        w_op_d     = w_latch ? (wr_req ? OP_WR : OP_RD) : r_op;
        w_busy_d   = (w_state_d != StIdle);
        w_done_d   = (w_state_d == StDone);
        w_mem_en_d = (w_state_d == StSetup) || (w_state_d == StAccess);
        w_mem_we_d = w_mem_en_d && (w_op_d == OP_WR);
        w_err_d    = (r_state == StIdle) && rd_req && wr_req;
    end

    // Request latches: address, write data and direction frozen for the access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_op    <= w_op_d;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
        end
    end

    // Output registers; read data captured on the edge that raises done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
            r_mem_en <= w_mem_en_d;
            r_mem_we <= w_mem_we_d;
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata_out = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: default build plus WAIT_CYCLES=1 and =15 builds on shared inputs.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_in, wdata_in;
    logic        rd_req, wr_req;

    logic        busy_a, done_a, err_a, mem_en_a, mem_we_a;
    logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        busy_b, done_b, err_b, mem_en_b, mem_we_b;
    logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        busy_c, done_c, err_c, mem_en_c, mem_we_c;
    logic [15:0] rdata_c, mem_addr_c, mem_wdata_c, mem_rdata_c;

    int n_checks = 0;
    int n_errors = 0;

    bit [15:0] mem [0:65535];
    bit        written [0:65535];

    always #5 clk = ~clk;

    mem_ctrl u_dut_a (
        .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_req(rd_req), .wr_req(wr_req), .busy(busy_a), .done(done_a), .err(err_a),
        .rdata_out(rdata_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
    );

    mem_ctrl #(.WAIT_CYCLES(1)) u_dut_b (
        .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_req(rd_req), .wr_req(wr_req), .busy(busy_b), .done(done_b), .err(err_b),
        .rdata_out(rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
    );

    mem_ctrl #(.WAIT_CYCLES(15)) u_dut_c (
        .clk(clk), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in),
        .rd_req(rd_req), .wr_req(wr_req), .busy(busy_c), .done(done_c), .err(err_c),
        .rdata_out(rdata_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
        .mem_en(mem_en_c), .mem_we(mem_we_c), .mem_rdata(mem_rdata_c)
    );

    // Secondary builds see the inverted address as read data
    assign mem_rdata_b = ~mem_addr_b;
    assign mem_rdata_c = ~mem_addr_c;

    function automatic logic [15:0] preset(input logic [15:0] a);
        case (a)
            16'h1234: return 16'hBEEF;
            16'h0010: return 16'h1111;
            16'h0002: return 16'h2222;
            default:  return 16'h0000;
        endcase
    endfunction

    // Synchronous memory behind the default build
    always @(posedge clk) begin
        if (mem_en_a) begin
            if (mem_we_a) begin
                mem[mem_addr_a]     <= mem_wdata_a;
                written[mem_addr_a] <= 1'b1;
            end else begin
                mem_rdata_a <= written[mem_addr_a] ? mem[mem_addr_a] : preset(mem_addr_a);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy_a),      32'd0);
        check({tag, "_done"},  32'(done_a),      32'd0);
        check({tag, "_err"},   32'(err_a),       32'd0);
        check({tag, "_rdata"}, 32'(rdata_a),     32'd0);
        check({tag, "_addr"},  32'(mem_addr_a),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata_a), 32'd0);
        check({tag, "_en"},    32'(mem_en_a),    32'd0);
        check({tag, "_we"},    32'(mem_we_a),    32'd0);
    endtask

    // One access on the default build, checked cycle by cycle through the idle cycle after done
    task automatic do_access(input string tag, input logic is_wr, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] exp_rd);
        @(negedge clk);
        addr_in  = a;
        wdata_in = wd;
        rd_req   = !is_wr;
        wr_req   = is_wr;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            wr_req = 1'b0;
            check({tag, "_en"},   32'(mem_en_a), 32'(k <= 3));
            check({tag, "_we"},   32'(mem_we_a), 32'(is_wr && (k <= 3)));
            check({tag, "_done"}, 32'(done_a),   32'(k == 4));
            check({tag, "_busy"}, 32'(busy_a),   32'(k <= 4));
            if (k <= 3) begin
                check({tag, "_addr"}, 32'(mem_addr_a), 32'(a));
                if (is_wr) check({tag, "_wdata"}, 32'(mem_wdata_a), 32'(wd));
            end
            if (k == 4) check({tag, "_rdata"}, 32'(rdata_a), 32'(exp_rd));
        end
    endtask

    task automatic wait_all_idle(input string tag);
        int n = 0;
        while ((busy_a || busy_b || busy_c) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(n < 60), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int first_a, second_a, first_b, second_b, first_c, second_c;

        reset    = 1'b1;
        addr_in  = '0;
        wdata_in = '0;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // Read with default wait states
        do_access("rd", 1'b0, 16'h1234, 16'h0000, 16'hBEEF);

        // Write leaves read data alone and lands in memory
        do_access("wr", 1'b1, 16'h00FF, 16'hA5A5, 16'hBEEF);
        check("wr_mem", 32'(mem[16'h00FF]), 32'h0000A5A5);

        // Illegal double request
        @(negedge clk);
        rd_req = 1'b1;
        wr_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        check("ill_err",  32'(err_a),    32'd1);
        check("ill_busy", 32'(busy_a),   32'd0);
        check("ill_en",   32'(mem_en_a), 32'd0);
        @(negedge clk);
        check("ill_err_pulse", 32'(err_a),    32'd0);
        check("ill_en2",       32'(mem_en_a), 32'd0);
        wait_all_idle("ill");

        // Requests and input changes while busy are ignored
        @(negedge clk);
        addr_in = 16'h0010;
        rd_req  = 1'b1;
        dcnt    = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_req   = 1'b0;
                wr_req   = 1'b1;
                addr_in  = 16'hFFFF;
                wdata_in = 16'hDEAD;
            end
            if (k == 4) wr_req = 1'b0;
            if (done_a) dcnt++;
            if (k <= 3) check("bsy_addr", 32'(mem_addr_a), 32'h00000010);
            check("bsy_we", 32'(mem_we_a), 32'd0);
        end
        check("bsy_done_count", 32'(dcnt), 32'd1);
        check("bsy_no_write",   32'(written[16'hFFFF]), 32'd0);
        check("bsy_rdata",      32'(rdata_a), 32'h00001111);
        wait_all_idle("bsy");

        // Reset during ACCESS abandons the access
        @(negedge clk);
        addr_in = 16'h1234;
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        check("rst_in_access", 32'(mem_en_a), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("rst_mid");
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_a) dcnt++;
        end
        check("rst_no_done", 32'(dcnt), 32'd0);
        do_access("rd2", 1'b0, 16'h0002, 16'h0000, 16'h2222);
        wait_all_idle("pre_lat");

        // Back-to-back reads on all three builds; done at W+2 and 2W+5
        @(negedge clk);
        addr_in = 16'h0002;
        rd_req  = 1'b1;
        first_a = 0; second_a = 0;
        first_b = 0; second_b = 0;
        first_c = 0; second_c = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (done_a) begin
                if (first_a == 0) first_a = k; else if (second_a == 0) second_a = k;
            end
            if (done_b) begin
                if (first_b == 0) first_b = k; else if (second_b == 0) second_b = k;
            end
            if (done_c) begin
                if (first_c == 0) first_c = k; else if (second_c == 0) second_c = k;
            end
            if (k == 4) check("b2b_busy_done", 32'(busy_a), 32'd1);
            if (k == 5) check("b2b_busy_gap",  32'(busy_a), 32'd0);
            if (k == 6) check("b2b_busy_next", 32'(busy_a), 32'd1);
            if (k == 35) rd_req = 1'b0;
        end
        check("lat_w2_first",   32'(first_a),  32'd4);
        check("lat_w2_second",  32'(second_a), 32'd9);
        check("lat_w1_first",   32'(first_b),  32'd3);
        check("lat_w1_second",  32'(second_b), 32'd7);
        check("lat_w15_first",  32'(first_c),  32'd17);
        check("lat_w15_second", 32'(second_c), 32'd35);
        check("w1_rdata",  32'(rdata_b), 32'h0000FFFD);
        check("w15_rdata", 32'(rdata_c), 32'h0000FFFD);
        wait_all_idle("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
